wb_burst_fifo: RTL and testbench
================================

// Module: wb_burst_fifo
// PURPOSE
//  Downstream sink for the wb_prefetch output (b-side) Wishbone port.
//  Accepts single and burst writes of prefetched words into a DEPTH-entry FIFO.
//  Presents the words to a byte-stream consumer (SPI/host transmit path) via a first-word-fall-through valid/ready port.
//  room_o tells the prefetch controller when a whole burst of BSIZE words fits, so it never overruns the buffer.
// PARAMETERS
//  WIDTH  8   data word width (matches prefetch WIDTH)
//  ABITS  4   log2 FIFO depth; DEPTH = 1<<ABITS = 16
//  BSIZE  5   burst length in words; room_o threshold; BSIZE <= DEPTH is required
// PORTS
//  clk_i    in   1        bus/system clock; all logic on rising edge
//  rst_ni   in   1        reset, asynchronous, active-low
//  clr_i    in   1        synchronous flush of FIFO contents and overflow flag
//  s_cyc_i  in   1        Wishbone cycle from prefetch
//  s_stb_i  in   1        Wishbone strobe; one transfer per cycle that is high
//  s_we_i   in   1        1 = write (push word); 0 = status read
//  s_bst_i  in   1        burst-in-progress hint; informational, no effect on acceptance
//  s_ack_o  out  1        acknowledge, one per accepted strobe
//  s_adr_i  in   ABITS+2  address; ignored (FIFO is a single port location)
//  s_dat_i  in   WIDTH    write data
//  s_dat_o  out  WIDTH    read data = level, zero-extended or truncated to WIDTH
//  room_o   out  1        1 when free entries >= BSIZE
//  ovf_o    out  1        sticky: a write arrived while full and was dropped
//  level_o  out  ABITS+1  current occupancy, 0..DEPTH
//  valid_o  out  1        FIFO non-empty; dat_o holds head word
//  ready_i  in   1        consumer pop request
//  dat_o    out  WIDTH    head word (FWFT)
// BEHAVIOUR
//  Reset (rst_ni low, asynchronous):
//   - pointers and count are 0.
//   - s_ack_o=0, s_dat_o=0, ovf_o=0, level_o=0, valid_o=0, dat_o undefined-but-ignored.
//   - room_o=1, combinational from count.
//   - Reset mid-burst discards the buffer and any pending ack.
//  Bus handshake: a strobe is sampled at edge N when s_cyc_i && s_stb_i.
//   - s_ack_o=1 for the cycle after edge N, exactly one ack per sampled strobe.
//   - Back-to-back strobes give back-to-back acks.
//   - Writes are always acked, even when dropped; no wait states.
//  Push = sampled strobe && s_we_i.
//   - Accepted when count<DEPTH, or when count==DEPTH and a pop happens on the same edge.
//   - Otherwise the word is dropped and ovf_o sets on that edge.
//  Pop = valid_o && ready_i at an edge; ready_i while empty is ignored.
//  Count update: push-only +1, pop-only -1, push+pop unchanged.
//   - Push+pop at count==0 is push-only; no bypass, the word appears next cycle.
//  Latency: a word pushed at edge N appears on valid_o/dat_o after edge N, if it is the new head.
//  Storage: distributed RAM, written at the push edge, read asynchronously at the read pointer.
//  Pointers: ABITS wide, wrap DEPTH-1 -> 0 naturally; count is ABITS+1 bits to separate full from empty.
//  Status read (sampled strobe, !s_we_i): s_dat_o <= level at edge N, valid with the ack; no FIFO side effects.
//  room_o = (DEPTH - count) >= BSIZE, combinational, so it updates in the cycle after the push/pop edge.
//  clr_i at an edge: count, pointers and ovf_o go to 0.
//   - clr_i overrides a push/pop on the same edge; that word is discarded.
//   - clr_i does not suppress the ack for a strobe on that edge.
//  ovf_o is cleared only by reset or clr_i.
// TESTING
//  1. Reset, then 5-word burst write 0x11..0x15, ready_i=0.
//     -> acks on 5 consecutive cycles; level_o=5; valid_o=1; dat_o=0x11; room_o=1 (11 free).
//  2. Keep ready_i=0 and write 11 more words.
//     -> level_o=16; room_o falls when level_o reaches 12; 17th write acked but dropped, ovf_o=1, level_o stays 16.
//  3. FIFO full, drive a push and ready_i=1 on the same edge.
//     -> push accepted; level_o stays 16; ovf_o unchanged; head advances one word.
//  4. Write 20 words with ready_i=1 continuously.
//     -> output order matches input exactly across pointer wrap; level_o never exceeds 2; ovf_o=0.
//  5. Status read with level=7 -> s_ack_o the next cycle with s_dat_o=0x07; level unchanged.
//  6. With level=3, assert clr_i together with a push; then separately pull rst_ni low mid-burst.
//     -> clr: level_o=0, valid_o=0, ack still issued.
//     -> reset: all outputs take reset values immediately, no ack after release.

Source files
------------

// File: rtl/wb_burst_fifo.sv
// ============================================================================
//  Module   : wb_burst_fifo
//  Purpose  : Wishbone write sink feeding a first-word-fall-through FIFO,
//             with burst-room indication and sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_burst_fifo #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4,
    parameter int BSIZE = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               s_cyc_i,
    input  logic               s_stb_i,
    input  logic               s_we_i,
    input  logic               s_bst_i,
    output logic               s_ack_o,
    input  logic [ABITS+1:0]   s_adr_i,
    input  logic [WIDTH-1:0]   s_dat_i,
    output logic [WIDTH-1:0]   s_dat_o,
    output logic               room_o,
    output logic               ovf_o,
    output logic [ABITS:0]     level_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   dat_o
);

    localparam logic [ABITS:0] c_DEPTH = (ABITS+1)'(1 << ABITS);
    localparam logic [ABITS:0] c_BSIZE = (ABITS+1)'(BSIZE);

    logic [WIDTH-1:0]   r_mem [0:(1<<ABITS)-1];
    logic [ABITS-1:0]   r_wr_ptr;
    logic [ABITS-1:0]   r_rd_ptr;
    logic [ABITS:0]     r_count;
    logic               r_ovf;
    logic               r_ack;
    logic [WIDTH-1:0]   r_rdat;

    logic               w_stb;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [WIDTH+ABITS:0] w_lvl_ext;
    logic [WIDTH-1:0]   w_lvl;
    logic               w_unused;

    // Address and burst hint carry no meaning for a single-location sink.
    assign w_unused   = ^{s_bst_i, s_adr_i};

    assign w_stb      = s_cyc_i && s_stb_i;
    assign w_push_req = w_stb && s_we_i;
    assign w_pop      = (r_count != '0) && ready_i;
    assign w_full     = (r_count == c_DEPTH);
    // A full FIFO still takes a word if the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_lvl_ext  = {{WIDTH{1'b0}}, r_count};
    assign w_lvl      = w_lvl_ext[WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wr_ptr] <= s_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_ack    <= 1'b0;
            r_rdat   <= '0;
        end else begin
            r_ack <= w_stb;
            if (w_stb && !s_we_i) begin
                r_rdat <= w_lvl;
            end
            if (clr_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ABITS'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ABITS'(1);
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (ABITS+1)'(1);
                    2'b01:   r_count <= r_count - (ABITS+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign s_ack_o = r_ack;
    assign s_dat_o = r_rdat;
    assign ovf_o   = r_ovf;
    assign level_o = r_count;
    assign valid_o = (r_count != '0);
    assign dat_o   = r_mem[r_rd_ptr];
    assign room_o  = (c_DEPTH - r_count) >= c_BSIZE;

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_fifo.sv
// ============================================================================
//  Module   : tb_wb_burst_fifo
//  Purpose  : Directed self-checking bench for wb_burst_fifo.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_burst_fifo;

    logic       clk;
    logic       rst_ni;
    logic       clr_i;
    logic       s_cyc_i;
    logic       s_stb_i;
    logic       s_we_i;
    logic       s_bst_i;
    logic       s_ack_o;
    logic [5:0] s_adr_i;
    logic [7:0] s_dat_i;
    logic [7:0] s_dat_o;
    logic       room_o;
    logic       ovf_o;
    logic [4:0] level_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] dat_o;

    int n_cmp;
    int n_err;

    wb_burst_fifo #(.WIDTH(8), .ABITS(4), .BSIZE(5)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_bst_i (s_bst_i),
        .s_ack_o (s_ack_o),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_dat_o (s_dat_o),
        .room_o  (room_o),
        .ovf_o   (ovf_o),
        .level_o (level_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .dat_o   (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        n_cmp++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", s_ack_o); end
        n_cmp++; if (s_dat_o !== 8'h00) begin n_err++; $display("FAIL reset_sdat: got %h want 00", s_dat_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (room_o !== 1'b1) begin n_err++; $display("FAIL reset_room: got %b want 1", room_o); end
        rst_ni = 1'b1;
        step();
    endtask

    // Five-word burst, consumer stalled.
    task automatic test_burst();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_bst_i = 1'b1;
            s_dat_i = 8'h11 + 8'(i);
            step();
            n_cmp++; if (s_ack_o !== 1'b1) begin n_err++; $display("FAIL burst_ack[%0d]: got %b want 1", i, s_ack_o); end
        end
        s_stb_i = 1'b0; s_cyc_i = 1'b0; s_bst_i = 1'b0;
        n_cmp++; if (level_o !== 5'd5) begin n_err++; $display("FAIL burst_level: got %0d want 5", level_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL burst_valid: got %b want 1", valid_o); end
        n_cmp++; if (dat_o !== 8'h11) begin n_err++; $display("FAIL burst_head: got %h want 11", dat_o); end
        n_cmp++; if (room_o !== 1'b1) begin n_err++; $display("FAIL burst_room: got %b want 1", room_o); end
        step();
        n_cmp++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL burst_ack_idle: got %b want 0", s_ack_o); end
    endtask

    // Fill to 16, watch room fall at 12, then overflow on the 17th write.
    task automatic test_fill();
        logic exp_room;
        for (int i = 0; i < 11; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
            s_dat_i = 8'h16 + 8'(i);
            step();
            exp_room = (6 + i) <= 11;
            n_cmp++; if (level_o !== 5'(6 + i)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level_o, 6 + i); end
            n_cmp++; if (room_o !== exp_room) begin n_err++; $display("FAIL fill_room[%0d]: got %b want %b", i, room_o, exp_room); end
        end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early: got %b want 0", ovf_o); end
        s_dat_i = 8'hEE;
        step();
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        n_cmp++; if (s_ack_o !== 1'b1) begin n_err++; $display("FAIL drop_ack: got %b want 1", s_ack_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL drop_ovf: got %b want 1", ovf_o); end
        n_cmp++; if (level_o !== 5'd16) begin n_err++; $display("FAIL drop_level: got %0d want 16", level_o); end
        n_cmp++; if (dat_o !== 8'h11) begin n_err++; $display("FAIL drop_head: got %h want 11", dat_o); end
    endtask

    // Push and pop together on a full FIFO, then drain and check order.
    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_dat_i = 8'hA5;
        ready_i = 1'b1;
        step();
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        n_cmp++; if (level_o !== 5'd16) begin n_err++; $display("FAIL fullpp_level: got %0d want 16", level_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL fullpp_ovf: got %b want 1", ovf_o); end
        n_cmp++; if (dat_o !== 8'h12) begin n_err++; $display("FAIL fullpp_head: got %h want 12", dat_o); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? (8'h12 + 8'(i)) : 8'hA5;
            n_cmp++; if (dat_o !== exp_d) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, dat_o, exp_d); end
            step();
        end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", valid_o); end
        step();
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL pop_empty_level: got %0d want 0", level_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf_o); end
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", ovf_o); end
    endtask

    // Streaming 20 words with the consumer always ready; crosses pointer wrap.
    task automatic test_back_to_back();
        logic [7:0] q[$];
        int guard;
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
            s_dat_i = 8'h40 + 8'(i);
            if (q.size() > 0) begin
                n_cmp++; if (dat_o !== q[0]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, dat_o, q[0]); end
                void'(q.pop_front());
            end
            q.push_back(s_dat_i);
            step();
            n_cmp++; if (s_ack_o !== 1'b1) begin n_err++; $display("FAIL stream_ack[%0d]: got %b want 1", i, s_ack_o); end
            n_cmp++; if (level_o !== 5'(q.size()) || level_o > 5'd2) begin n_err++; $display("FAIL stream_level[%0d]: got %0d want %0d", i, level_o, q.size()); end
        end
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            n_cmp++; if (valid_o !== 1'b1 || dat_o !== q[0]) begin n_err++; $display("FAIL stream_tail: got %b/%h want 1/%h", valid_o, dat_o, q[0]); end
            void'(q.pop_front());
            step();
            guard++;
        end
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL stream_end_level: got %0d want 0", level_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL stream_ovf: got %b want 0", ovf_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_status();
        for (int i = 0; i < 7; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
            s_dat_i = 8'h30 + 8'(i);
            step();
        end
        s_we_i = 1'b0;
        step();
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        n_cmp++; if (s_ack_o !== 1'b1) begin n_err++; $display("FAIL status_ack: got %b want 1", s_ack_o); end
        n_cmp++; if (s_dat_o !== 8'h07) begin n_err++; $display("FAIL status_data: got %h want 07", s_dat_o); end
        n_cmp++; if (level_o !== 5'd7) begin n_err++; $display("FAIL status_level: got %0d want 7", level_o); end
        n_cmp++; if (dat_o !== 8'h30) begin n_err++; $display("FAIL status_head: got %h want 30", dat_o); end
    endtask

    task automatic test_clear_and_reset();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
            s_dat_i = 8'h61 + 8'(i);
            step();
        end
        n_cmp++; if (level_o !== 5'd3) begin n_err++; $display("FAIL clr_pre_level: got %0d want 3", level_o); end
        s_dat_i = 8'h64;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
        n_cmp++; if (s_ack_o !== 1'b1) begin n_err++; $display("FAIL clr_ack: got %b want 1", s_ack_o); end
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL clr_level: got %0d want 0", level_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", valid_o); end
        step();
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL clr_discard: got %0d want 0", level_o); end
        // Mid-burst asynchronous reset
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_dat_i = 8'h70;
        step();
        s_dat_i = 8'h71;
        step();
        n_cmp++; if (level_o !== 5'd2) begin n_err++; $display("FAIL rst_pre_level: got %0d want 2", level_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL arst_ack: got %b want 0", s_ack_o); end
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", valid_o); end
        n_cmp++; if (room_o !== 1'b1) begin n_err++; $display("FAIL arst_room: got %b want 1", room_o); end
        step();
        n_cmp++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL arst_hold_ack: got %b want 0", s_ack_o); end
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        rst_ni = 1'b1;
        step();
        n_cmp++; if (s_ack_o !== 1'b0) begin n_err++; $display("FAIL arst_release_ack: got %b want 0", s_ack_o); end
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL arst_release_level: got %0d want 0", level_o); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_ni = 1'b0; clr_i = 1'b0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_bst_i = 1'b0;
        s_adr_i = 6'd0; s_dat_i = 8'h00; ready_i = 1'b0;
        test_reset();
        test_burst();
        test_fill();
        test_full_push_pop();
        test_back_to_back();
        test_status();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
